// File: rtl/immediate_pipe_unit_pkg.sv
// Shared constants and format-select encodings for the immediate pipe unit.
// Optional feature macro: IMM_PIPE_ILLEGAL_EN (adds the o_Illegal output).
package immediate_pipe_unit_pkg;

   localparam int IMM_SEL_WIDTH = 2;

   // Select values 3'd6 is unused and 3'd7 is the explicit "unknown" code;
   // both fall through to a zero immediate.
   typedef enum logic [IMM_SEL_WIDTH:0] {
      IMM_U_TYPE       = 3'd0,
      IMM_J_TYPE       = 3'd1,
      IMM_I_TYPE       = 3'd2,
      IMM_S_TYPE       = 3'd3,
      IMM_B_TYPE       = 3'd4,
      IMM_Z_TYPE       = 3'd5,
      IMM_UNKNOWN_TYPE = 3'd7
   } imm_sel_e;

   localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/immediate_format_extract.sv
// Combinational extraction and extension of RISC-V immediates to XLEN bits.
// Optional feature macro: IMM_PIPE_ILLEGAL_EN (adds the o_Illegal output).
module immediate_format_extract
   import immediate_pipe_unit_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [IMM_SEL_WIDTH:0] i_Imm_Select,
   input  logic [31:7]            i_Instruction_No_Opcode,
`ifdef IMM_PIPE_ILLEGAL_EN
   output logic                   o_Illegal,
`endif
   output logic [XLEN-1:0]        o_Immediate
);

   // Decode the select, fill the upper bits with the sign first, then overlay the
   // format's low field; Z is the only zero-extended format.
   always_comb begin
      o_Immediate = '0;
`ifdef IMM_PIPE_ILLEGAL_EN
      o_Illegal   = 1'b0;
`endif
      case (i_Imm_Select)
         IMM_U_TYPE: begin
            o_Immediate       = {XLEN{i_Instruction_No_Opcode[31]}};
            o_Immediate[31:0] = {i_Instruction_No_Opcode[31:12], 12'b0};
         end
         IMM_J_TYPE: begin
            o_Immediate       = {XLEN{i_Instruction_No_Opcode[31]}};
            o_Immediate[20:0] = {i_Instruction_No_Opcode[31], i_Instruction_No_Opcode[19:12],
                                 i_Instruction_No_Opcode[20], i_Instruction_No_Opcode[30:21], 1'b0};
         end
         IMM_I_TYPE: begin
            o_Immediate       = {XLEN{i_Instruction_No_Opcode[31]}};
            o_Immediate[11:0] = i_Instruction_No_Opcode[31:20];
         end
         IMM_S_TYPE: begin
            o_Immediate       = {XLEN{i_Instruction_No_Opcode[31]}};
            o_Immediate[11:0] = {i_Instruction_No_Opcode[31:25], i_Instruction_No_Opcode[11:7]};
         end
         IMM_B_TYPE: begin
            o_Immediate       = {XLEN{i_Instruction_No_Opcode[31]}};
            o_Immediate[12:0] = {i_Instruction_No_Opcode[31], i_Instruction_No_Opcode[7],
                                 i_Instruction_No_Opcode[30:25], i_Instruction_No_Opcode[11:8], 1'b0};
         end
         IMM_Z_TYPE: begin
            o_Immediate[4:0] = i_Instruction_No_Opcode[19:15];
         end
         default: begin
`ifdef IMM_PIPE_ILLEGAL_EN
            o_Illegal = 1'b1;
`endif
         end
      endcase
   end

endmodule

// File: rtl/immediate_pipe_unit.sv
// Registered, back-pressured immediate generator with a 2-entry result FIFO.
// Optional feature macro: IMM_PIPE_ILLEGAL_EN (adds o_Illegal, carried per entry).
module immediate_pipe_unit
   import immediate_pipe_unit_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int TAG_WIDTH = 5
) (
   input  logic                   i_Clock,
   input  logic                   i_Reset,
   input  logic                   i_Flush,
   input  logic                   i_Valid,
   output logic                   o_Ready,
   input  logic [IMM_SEL_WIDTH:0] i_Imm_Select,
   input  logic [31:7]            i_Instruction_No_Opcode,
   input  logic [TAG_WIDTH-1:0]   i_Tag,
   output logic                   o_Valid,
   input  logic                   i_Ready,
   output logic [XLEN-1:0]        o_Immediate,
`ifdef IMM_PIPE_ILLEGAL_EN
   output logic                   o_Illegal,
`endif
   output logic [TAG_WIDTH-1:0]   o_Tag
);

   logic [XLEN-1:0]      w_Immediate;
   logic                 w_Push;
   logic                 w_Pop;
   logic [1:0]           r_Count;
   logic                 r_RdPtr;
   logic                 r_WrPtr;
   logic [XLEN-1:0]      r_Imm [FIFO_DEPTH];
   logic [TAG_WIDTH-1:0] r_Tag [FIFO_DEPTH];
`ifdef IMM_PIPE_ILLEGAL_EN
   logic                 w_Illegal;
   logic                 r_Ill [FIFO_DEPTH];
`endif

   immediate_format_extract #(
      .XLEN(XLEN)
   ) u_Extract (
      .i_Imm_Select           (i_Imm_Select),
      .i_Instruction_No_Opcode(i_Instruction_No_Opcode),
`ifdef IMM_PIPE_ILLEGAL_EN
      .o_Illegal              (w_Illegal),
`endif
      .o_Immediate            (w_Immediate)
   );

   // Handshake and head-of-FIFO outputs, all derived from registered state so
   // o_Ready never depends combinationally on i_Ready.
   always_comb begin
      o_Valid     = (r_Count != 2'd0);
      o_Ready     = (r_Count != 2'd2);
      w_Push      = i_Valid && o_Ready;
      w_Pop       = o_Valid && i_Ready;
      o_Immediate = o_Valid ? r_Imm[r_RdPtr] : '0;
      o_Tag       = o_Valid ? r_Tag[r_RdPtr] : '0;
`ifdef IMM_PIPE_ILLEGAL_EN
      o_Illegal   = o_Valid ? r_Ill[r_RdPtr] : 1'b0;
`endif
   end

   // Occupancy and pointers; flush empties the FIFO and discards any same-cycle push.
   always_ff @(posedge i_Clock) begin
      if (i_Reset || i_Flush) begin
         r_Count <= 2'd0;
         r_RdPtr <= 1'b0;
         r_WrPtr <= 1'b0;
      end else begin
         if (w_Push) r_WrPtr <= ~r_WrPtr;
         if (w_Pop)  r_RdPtr <= ~r_RdPtr;
         r_Count <= r_Count + {1'b0, w_Push} - {1'b0, w_Pop};
      end
   end

   // Entry storage; contents are only visible through o_* while counted as valid.
   always_ff @(posedge i_Clock) begin
      if (w_Push && !i_Reset && !i_Flush) begin
         r_Imm[r_WrPtr] <= w_Immediate;
         r_Tag[r_WrPtr] <= i_Tag;
`ifdef IMM_PIPE_ILLEGAL_EN
         r_Ill[r_WrPtr] <= w_Illegal;
`endif
      end
   end

endmodule

// File: tb/tb_immediate_pipe_unit.sv
// Self-checking bench for immediate_pipe_unit at XLEN=32 and XLEN=64 in parallel.
// Optional feature macro: IMM_PIPE_ILLEGAL_EN (also checks o_Illegal).
module tb_immediate_pipe_unit;
   import immediate_pipe_unit_pkg::*;

   typedef struct {
      logic [2:0]  sel;
      logic [31:0] instr;
      logic [4:0]  tag;
      logic [63:0] expImm;
      logic        expIll;
   } vec_t;

   localparam int NUM_VECS = 14;

   logic        clock = 1'b0;
   logic        reset;
   logic        flush;
   logic        iValid;
   logic        iReady;
   logic [2:0]  immSelect;
   logic [31:7] instrBits;
   logic [4:0]  iTag;

   logic        ready32, valid32, ready64, valid64;
   logic [31:0] imm32;
   logic [63:0] imm64;
   logic [4:0]  tag32, tag64;
`ifdef IMM_PIPE_ILLEGAL_EN
   logic        ill32, ill64;
`endif

   int   nChecks = 0;
   int   nPassed = 0;
   vec_t vecs [NUM_VECS];

   // Free-running clock, 10 time-unit period.
   always #5 clock = ~clock;

   immediate_pipe_unit #(.XLEN(32), .TAG_WIDTH(5)) dut32 (
      .i_Clock                (clock),
      .i_Reset                (reset),
      .i_Flush                (flush),
      .i_Valid                (iValid),
      .o_Ready                (ready32),
      .i_Imm_Select           (immSelect),
      .i_Instruction_No_Opcode(instrBits),
      .i_Tag                  (iTag),
      .o_Valid                (valid32),
      .i_Ready                (iReady),
      .o_Immediate            (imm32),
`ifdef IMM_PIPE_ILLEGAL_EN
      .o_Illegal              (ill32),
`endif
      .o_Tag                  (tag32)
   );

   immediate_pipe_unit #(.XLEN(64), .TAG_WIDTH(5)) dut64 (
      .i_Clock                (clock),
      .i_Reset                (reset),
      .i_Flush                (flush),
      .i_Valid                (iValid),
      .o_Ready                (ready64),
      .i_Imm_Select           (immSelect),
      .i_Instruction_No_Opcode(instrBits),
      .i_Tag                  (iTag),
      .o_Valid                (valid64),
      .i_Ready                (iReady),
      .o_Immediate            (imm64),
`ifdef IMM_PIPE_ILLEGAL_EN
      .o_Illegal              (ill64),
`endif
      .o_Tag                  (tag64)
   );

   // Single comparison with pass/fail bookkeeping.
   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
      nChecks++;
      if (actual === expected) nPassed++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   // Present one request on the input side.
   task automatic applyStimulus(input vec_t v);
      iValid    = 1'b1;
      immSelect = v.sel;
      instrBits = v.instr[31:7];
      iTag      = v.tag;
   endtask

   // Head entry of both instances must match the vector.
   task automatic checkOutput(input string name, input vec_t v);
      check({name, " valid32"}, {63'b0, valid32}, 64'd1);
      check({name, " valid64"}, {63'b0, valid64}, 64'd1);
      check({name, " imm64"}, imm64, v.expImm);
      check({name, " imm32"}, {32'b0, imm32}, {32'b0, v.expImm[31:0]});
      check({name, " tag32"}, {59'b0, tag32}, {59'b0, v.tag});
      check({name, " tag64"}, {59'b0, tag64}, {59'b0, v.tag});
`ifdef IMM_PIPE_ILLEGAL_EN
      check({name, " ill32"}, {63'b0, ill32}, {63'b0, v.expIll});
      check({name, " ill64"}, {63'b0, ill64}, {63'b0, v.expIll});
`endif
   endtask

   // Both instances empty with outputs zero and ready high.
   task automatic checkEmpty(input string name);
      check({name, " valid"}, {62'b0, valid32, valid64}, 64'd0);
      check({name, " imm64"}, imm64, 64'd0);
      check({name, " imm32"}, {32'b0, imm32}, 64'd0);
      check({name, " tags"}, {54'b0, tag32, tag64}, 64'd0);
      check({name, " ready"}, {62'b0, ready32, ready64}, 64'd3);
   endtask

   task automatic checkReady(input string name, input logic expected);
      check({name, " ready32"}, {63'b0, ready32}, {63'b0, expected});
      check({name, " ready64"}, {63'b0, ready64}, {63'b0, expected});
   endtask

   task automatic doReset();
      reset  = 1'b1;
      iValid = 1'b0;
      flush  = 1'b0;
      iReady = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      vecs[0]  = '{IMM_I_TYPE, 32'hFFF00093, 5'd1,  64'hFFFFFFFFFFFFFFFF, 1'b0};
      vecs[1]  = '{IMM_I_TYPE, 32'h00500093, 5'd2,  64'h0000000000000005, 1'b0};
      vecs[2]  = '{IMM_U_TYPE, 32'h800000B7, 5'd3,  64'hFFFFFFFF80000000, 1'b0};
      vecs[3]  = '{IMM_U_TYPE, 32'h12345037, 5'd4,  64'h0000000012345000, 1'b0};
      vecs[4]  = '{IMM_Z_TYPE, 32'h340FD073, 5'd5,  64'h000000000000001F, 1'b0};
      vecs[5]  = '{IMM_Z_TYPE, 32'h00045073, 5'd6,  64'h0000000000000008, 1'b0};
      vecs[6]  = '{IMM_J_TYPE, 32'h0080006F, 5'd7,  64'h0000000000000008, 1'b0};
      vecs[7]  = '{IMM_J_TYPE, 32'hFFDFF06F, 5'd8,  64'hFFFFFFFFFFFFFFFC, 1'b0};
      vecs[8]  = '{IMM_S_TYPE, 32'hFE112E23, 5'd9,  64'hFFFFFFFFFFFFFFFC, 1'b0};
      vecs[9]  = '{IMM_S_TYPE, 32'h00A12423, 5'd10, 64'h0000000000000008, 1'b0};
      vecs[10] = '{IMM_B_TYPE, 32'hFE000EE3, 5'd11, 64'hFFFFFFFFFFFFFFFC, 1'b0};
      vecs[11] = '{IMM_B_TYPE, 32'h00000463, 5'd12, 64'h0000000000000008, 1'b0};
      vecs[12] = '{3'd6,       32'hFFFFFFFF, 5'd13, 64'h0000000000000000, 1'b1};
      vecs[13] = '{IMM_UNKNOWN_TYPE, 32'hFFFFFFFF, 5'd14, 64'h0000000000000000, 1'b1};

      immSelect = '0;
      instrBits = '0;
      iTag      = '0;
      doReset();
      $display("[TB] reset state");
      checkEmpty("reset");

      // Back-to-back stream with consumer always ready: one result per cycle, in order.
      $display("[TB] streaming table vectors");
      iReady = 1'b1;
      for (int i = 0; i < NUM_VECS; i++) begin
         applyStimulus(vecs[i]);
         @(negedge clock);
         checkOutput($sformatf("vec%0d", i), vecs[i]);
         checkReady($sformatf("vec%0d", i), 1'b1);
      end
      iValid = 1'b0;
      @(negedge clock);
      checkEmpty("drain");

      // Stall: third push refused, head held, full+pop cycle accepts nothing.
      $display("[TB] back-pressure");
      doReset();
      applyStimulus(vecs[0]);
      @(negedge clock);
      checkOutput("stallA", vecs[0]);
      checkReady("stallA", 1'b1);
      applyStimulus(vecs[1]);
      @(negedge clock);
      checkOutput("stallFull", vecs[0]);
      checkReady("stallFull", 1'b0);
      applyStimulus(vecs[2]);
      @(negedge clock);
      checkOutput("stallHeld", vecs[0]);
      checkReady("stallHeld", 1'b0);
      iReady = 1'b1;
      applyStimulus(vecs[3]);
      @(negedge clock);
      checkOutput("popB", vecs[1]);
      checkReady("popB", 1'b1);
      iValid = 1'b0;
      @(negedge clock);
      checkEmpty("stallDrain");

      // Flush with a concurrent push, then a fresh push, then reset mid-stream.
      $display("[TB] flush and reset");
      doReset();
      applyStimulus(vecs[4]);
      @(negedge clock);
      applyStimulus(vecs[5]);
      @(negedge clock);
      checkReady("preFlush", 1'b0);
      flush = 1'b1;
      applyStimulus(vecs[6]);
      @(negedge clock);
      checkEmpty("flush");
      flush  = 1'b0;
      iValid = 1'b0;
      @(negedge clock);
      checkEmpty("flushDropped");
      iReady = 1'b1;
      applyStimulus(vecs[9]);
      @(negedge clock);
      checkOutput("postFlush", vecs[9]);
      iReady = 1'b0;
      applyStimulus(vecs[10]);
      @(negedge clock);
      reset = 1'b1;
      applyStimulus(vecs[11]);
      @(negedge clock);
      checkEmpty("midReset");
      reset  = 1'b0;
      iValid = 1'b0;
      @(negedge clock);
      checkEmpty("afterReset");

      $display("%0d/%0d checks passed", nPassed, nChecks);
      $finish;
   end

endmodule
